// File: rtl/pyth_leg_solver_pkg.sv
// ---------------------------------------------------------------------------
// pyth_pkg
//   Shared definitions for the Pythagorean leg solver:
//     W_DEF    default operand/result width
//     LATENCY  clock edges from the start-sampling edge to the edge that
//              raises done (done is visible in the following cycle)
//     state_t  controller states
// ---------------------------------------------------------------------------
package pyth_pkg;

    localparam int W_DEF   = 8;
    localparam int LATENCY = 2 * W_DEF + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SUB,
        ST_ROOT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pyth_leg_solver_if.sv
// ---------------------------------------------------------------------------
// pyth_leg_solver_if
//   Request/response bundle of the leg solver.
//     ena    global enable, low stalls the whole block
//     start  request strobe, honoured only while idle
//     r_in   hypotenuse (unsigned, W bits)
//     x_in   known leg  (unsigned, W bits)
//     busy   operation in flight
//     done   one-cycle completion pulse
//     err    x_in was larger than r_in
//     y_out  computed leg (unsigned, W bits)
//   master : requester side, slave : solver side.
// ---------------------------------------------------------------------------
interface pyth_leg_solver_if
    import pyth_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         ena;
    logic         start;
    logic [W-1:0] r_in;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] y_out;

    modport master (
        output ena, start, r_in, x_in,
        input  busy, done, err, y_out
    );

    modport slave (
        input  ena, start, r_in, x_in,
        output busy, done, err, y_out
    );

endinterface

// File: rtl/pyth_leg_solver_isqrt.sv
// ---------------------------------------------------------------------------
// pyth_isqrt_iter
//   Restoring bit-pair integer square root. A load strobe captures a 2W-bit
//   radicand; each step strobe consumes the next two radicand bits (MSB
//   first) and produces one result bit. After W steps
//     q   = floor(sqrt(n))
//     rem = n - q*q            (only when PYTH_LEG_ROUND_EN is defined)
//   Ports: clk, rst_n (async, active-low), load, step, rad_in, q, [rem].
//   Configuration macro: PYTH_LEG_ROUND_EN exposes the remainder port.
// ---------------------------------------------------------------------------
module pyth_isqrt_iter
    import pyth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [2*W-1:0] rad_in,
    output logic [W-1:0]   q
`ifdef PYTH_LEG_ROUND_EN
    ,
    output logic [W+1:0]   rem
`endif
);

    // Remainder never exceeds 2*q, so W+2 bits always hold it.
    localparam int RW = W + 2;

    logic [2*W-1:0] n_sh;
    logic [W-1:0]   q_r;
    logic [RW-1:0]  rem_r;

    logic [RW+1:0]  rem_t;
    logic [RW+1:0]  trial;
    logic           ge;
    logic [RW-1:0]  rem_nx;

    // Bring down the next bit pair and try subtracting (4q + 1).
    always_comb begin
        rem_t  = {rem_r, n_sh[2*W-1 -: 2]};
        trial  = {2'b00, q_r, 2'b01};
        ge     = (rem_t >= trial);
        rem_nx = ge ? RW'(rem_t - trial) : RW'(rem_t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sh  <= '0;
            q_r   <= '0;
            rem_r <= '0;
        end else if (load) begin
            n_sh  <= rad_in;
            q_r   <= '0;
            rem_r <= '0;
        end else if (step) begin
            n_sh  <= n_sh << 2;
            q_r   <= {q_r[W-2:0], ge};
            rem_r <= rem_nx;
        end
    end

    assign q = q_r;
`ifdef PYTH_LEG_ROUND_EN
    assign rem = rem_r;
`endif

endmodule

// File: rtl/pyth_leg_solver.sv
// ---------------------------------------------------------------------------
// pyth_leg_solver
//   Computes the missing leg y = isqrt(r*r - x*x) without multipliers:
//   two shift-add squarers (W cycles), one subtract cycle, a bit-serial
//   square root (W cycles) and a one-cycle result state. done and y_out
//   appear LATENCY edges after the edge that samples start.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pyth_leg_solver_if.slave (ena, start, r_in, x_in,
//            busy, done, err, y_out)
//   Configuration macro: PYTH_LEG_ROUND_EN selects round-to-nearest
//   (y = q+1 when rem > q); without it the result is floor(sqrt(n)).
// ---------------------------------------------------------------------------
module pyth_leg_solver
    import pyth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pyth_leg_solver_if.slave   bus
);

    state_t         state;
    state_t         state_nx;

    logic [W-1:0]   cnt;
    logic           last;

    // Squarer registers: multiplicand shifts left, multiplier shifts right.
    logic [2*W-1:0] r_mc;
    logic [2*W-1:0] x_mc;
    logic [W-1:0]   r_mp;
    logic [W-1:0]   x_mp;
    logic [2*W-1:0] r_sq;
    logic [2*W-1:0] x_sq;

    logic           x_gt_r;
    logic [2*W-1:0] rad;
    logic           err_flag;

    logic           root_load;
    logic           root_step;
    logic [W-1:0]   q;
    logic           round_up;
    logic [W-1:0]   y_nx;

    logic           done_q;
    logic           err_q;
    logic [W-1:0]   y_q;

    assign last = (cnt == W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.ena) begin
            unique case (state)
                ST_IDLE: if (bus.start) state_nx = ST_MUL;
                ST_MUL:  if (last)      state_nx = ST_SUB;
                ST_SUB:                 state_nx = ST_ROOT;
                ST_ROOT: if (last)      state_nx = ST_DONE;
                ST_DONE:                state_nx = ST_IDLE;
                default:                state_nx = ST_IDLE;
            endcase
        end
    end

    // A negative difference means x > r; the root then works on zero.
    always_comb begin
        x_gt_r = (x_sq > r_sq);
        rad    = x_gt_r ? '0 : (r_sq - x_sq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            r_mc     <= '0;
            x_mc     <= '0;
            r_mp     <= '0;
            x_mp     <= '0;
            r_sq     <= '0;
            x_sq     <= '0;
            err_flag <= 1'b0;
        end else if (bus.ena) begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mc     <= {{W{1'b0}}, bus.r_in};
                        x_mc     <= {{W{1'b0}}, bus.x_in};
                        r_mp     <= bus.r_in;
                        x_mp     <= bus.x_in;
                        r_sq     <= '0;
                        x_sq     <= '0;
                        cnt      <= '0;
                        err_flag <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (r_mp[0]) r_sq <= r_sq + r_mc;
                    if (x_mp[0]) x_sq <= x_sq + x_mc;
                    r_mc <= r_mc << 1;
                    x_mc <= x_mc << 1;
                    r_mp <= r_mp >> 1;
                    x_mp <= x_mp >> 1;
                    cnt  <= last ? '0 : cnt + 1'b1;
                end
                ST_SUB: begin
                    err_flag <= x_gt_r;
                    cnt      <= '0;
                end
                ST_ROOT: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign root_load = bus.ena && (state == ST_SUB);
    assign root_step = bus.ena && (state == ST_ROOT);

`ifdef PYTH_LEG_ROUND_EN
    logic [W+1:0] rem;
    // n lies closer to (q+1)^2 than to q^2 exactly when n - q^2 > q.
    assign round_up = (rem > {2'b00, q});
`else
    assign round_up = 1'b0;
`endif

    pyth_isqrt_iter #(
        .W (W)
    ) u_isqrt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (root_load),
        .step   (root_step),
        .rad_in (rad),
        .q      (q)
`ifdef PYTH_LEG_ROUND_EN
        ,
        .rem    (rem)
`endif
    );

    // q+1 cannot wrap: n <= (2^W-1)^2 keeps rem <= q whenever q is at maximum.
    assign y_nx = q + {{(W-1){1'b0}}, round_up};

    // Results are registered on the DONE edge so done, err and y_out
    // appear together; done holds through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            y_q    <= '0;
        end else if (bus.ena) begin
            done_q <= (state == ST_DONE);
            if (state == ST_DONE) begin
                err_q <= err_flag;
                y_q   <= err_flag ? '0 : y_nx;
            end
        end
    end

    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.y_out = y_q;

endmodule

// File: tb/tb_pyth_leg_solver.sv
// ---------------------------------------------------------------------------
// tb_pyth_leg_solver
//   Scoreboard bench for pyth_leg_solver. Each request pushes its expected
//   leg, error flag and completion cycle; a monitor compares on every done.
//   Build with PYTH_LEG_ROUND_EN to check the rounding variant.
// ---------------------------------------------------------------------------
module tb_pyth_leg_solver;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pyth_leg_solver_if #(.W(W)) bus ();

    pyth_leg_solver #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         e;
        int           at;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_y"},   32'(bus.y_out), 32'(mon_e.y));
                check({mon_e.name, "_err"}, 32'(bus.err),   32'(mon_e.e));
                check({mon_e.name, "_lat"}, 32'(cyc),       32'(mon_e.at));
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy || bus.done) begin
            n_chk++;
            $display("FAIL %s_idle_timeout: got busy=%0d done=%0d, expected idle", nm, bus.busy, bus.done);
        end
    endtask

    // Issues one request; returns at the negedge after the start edge
    // (plus any stall inserted early in the squaring phase).
    task automatic op(input string nm, input int r, input int x,
                      input int ey, input int ee, input int stall);
        exp_t e;
        wait_idle(nm);
        bus.r_in  = W'(r);
        bus.x_in  = W'(x);
        bus.start = 1'b1;
        e.y    = W'(ey);
        e.e    = ee[0];
        e.at   = cyc + 19 + stall;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        if (stall > 0) begin
            repeat (2) @(negedge clk);
            bus.ena = 1'b0;
            repeat (stall) @(negedge clk);
            bus.ena = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1);
    end

    initial begin
        int nb;
        bus.ena   = 1'b1;
        bus.start = 1'b0;
        bus.r_in  = '0;
        bus.x_in  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy),  0);
        check("rst_done", 32'(bus.done),  0);
        check("rst_err",  32'(bus.err),   0);
        check("rst_y",    32'(bus.y_out), 0);
        rst_n = 1'b1;

        // Basic case plus busy width
        op("t1_5_3", 5, 3, 4, 0, 0);
        nb = 0;
        while (bus.busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(nb), 18);

        op("t2_13_5",   13, 5,  12, 0, 0);
        op("t2_10_10",  10, 10, 0,  0, 0);
        op("t3_3_5",    3,  5,  0,  1, 0);
        op("t3_5_4",    5,  4,  3,  0, 0);
`ifdef PYTH_LEG_ROUND_EN
        op("t4_255_254", 255, 254, 23, 0, 0);
        op("x_7_2",      7,   2,   7,  0, 0);
`else
        op("t4_255_254", 255, 254, 22, 0, 0);
        op("x_7_2",      7,   2,   6,  0, 0);
`endif
        op("t4_255_0",   255, 0,   255, 0, 0);
        op("x_200_100",  200, 100, 173, 0, 0);
        op("x_0_1",      0,   1,   0,   1, 0);
        op("x_1_0",      1,   0,   1,   0, 0);

        // Stall in the squaring phase
        op("t5_stall", 13, 5, 12, 0, 5);

        // Start pulse during an operation must be ignored
        op("t5_ignore", 5, 3, 4, 0, 0);
        repeat (10) @(negedge clk);
        bus.r_in  = 8'd9;
        bus.x_in  = 8'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset during the root phase aborts without a done
        op("t6_abort", 200, 100, 173, 0, 0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(bus.busy),  0);
        check("t6_rst_done", 32'(bus.done),  0);
        check("t6_rst_err",  32'(bus.err),   0);
        check("t6_rst_y",    32'(bus.y_out), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        op("t6_after", 5, 3, 4, 0, 0);

        wait_idle("final");
        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
